// File: rtl/seq_div_16_8_if.sv
// seq_div_16_8_if: operand/result valid-ready bundle for the sequential divider
interface seq_div_16_8_if #(
    parameter int N_DIVIDEND = 16,
    parameter int N_DIVISOR  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_DIVIDEND-1:0] IN1;
    logic [N_DIVISOR-1:0]  IN2;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_DIVIDEND-1:0] Q;
    logic [N_DIVISOR-1:0]  R;
    logic                  div_by_zero;

    modport master (
        output in_valid, IN1, IN2, out_ready,
        input  in_ready, out_valid, Q, R, div_by_zero
    );

    modport slave (
        input  in_valid, IN1, IN2, out_ready,
        output in_ready, out_valid, Q, R, div_by_zero
    );
endinterface

// File: rtl/seq_div_16_8.sv
// seq_div_16_8: restoring unsigned divider, one quotient bit per clock, valid/ready on both sides
module seq_div_16_8 #(
    parameter int N_DIVIDEND = 16,
    parameter int N_DIVISOR  = 8
) (
    input logic          clk,
    input logic          rst,
    seq_div_16_8_if.slave bus
);
    localparam int CW = $clog2(N_DIVIDEND + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_n;
    logic [N_DIVIDEND-1:0] dvd, dvd_n;
    logic [N_DIVISOR-1:0]  dvs;
    logic [N_DIVISOR-1:0]  rem, rem_n;
    logic [N_DIVISOR:0]    t;
    logic [CW-1:0]         cnt;
    logic                  accept, zdiv, last, ge;
    logic [N_DIVIDEND-1:0] q_r;
    logic [N_DIVISOR-1:0]  r_r;
    logic                  dbz_r;

    assign bus.in_ready    = state == IDLE && !rst;
    assign bus.out_valid   = state == DONE;
    assign bus.Q           = q_r;
    assign bus.R           = r_r;
    assign bus.div_by_zero = dbz_r;

    assign accept = bus.in_valid && bus.in_ready;
    assign zdiv   = bus.IN2 == '0;
    assign last   = cnt == CW'(N_DIVIDEND - 1);

    // Compare at N_DIVISOR+1 bits; the kept remainder is always < divisor so it fits N_DIVISOR bits
    assign t     = {rem, dvd[N_DIVIDEND-1]};
    assign ge    = t >= {1'b0, dvs};
    assign rem_n = ge ? N_DIVISOR'(t - {1'b0, dvs}) : t[N_DIVISOR-1:0];
    assign dvd_n = {dvd[N_DIVIDEND-2:0], ge};

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (accept ? (zdiv ? DONE : CALC) : IDLE) :
                  state == CALC ? (last ? DONE : CALC) :
                  (bus.out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            dvd <= bus.IN1;
            dvs <= bus.IN2;
            rem <= '0;
            cnt <= '0;
            if (zdiv) begin
                q_r   <= '1;
                r_r   <= bus.IN1[N_DIVISOR-1:0];
                dbz_r <= 1'b1;
            end
        end else if (state == CALC) begin
            dvd <= dvd_n;
            rem <= rem_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                q_r   <= dvd_n;
                r_r   <= rem_n;
                dbz_r <= 1'b0;
            end
        end
    end
endmodule
